// File: rtl/uart_reg_pkg.sv
// Shared constants and state encoding for the UART register protocol,
// used by both the master and the far-end responder.
package uart_reg_pkg;

  localparam logic [7:0] PROTO_SET_REG = 8'h53;  // "S"
  localparam logic [7:0] PROTO_READ    = 8'h52;  // "R"
  localparam logic [7:0] PROTO_WRITE   = 8'h57;  // "W"

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_DONE,
    ST_RECV,
    ST_RESP
  } state_t;

  function automatic logic [7:0] op_byte(input logic write);
    return write ? PROTO_WRITE : PROTO_READ;
  endfunction

endpackage

// File: rtl/uart_reg_timeout.sv
// Reloadable down-counter: clear reloads, enable counts down to zero,
// expired flags a full TIMEOUT_CYCLES of enabled cycles without a clear.
module uart_reg_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic srst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (!srst_n) begin
      count <= LOAD;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = enable && (count == '0);

endmodule

// File: rtl/uart_reg_master.sv
// Initiator of the UART register protocol: serializes one read/write request
// as "S<index>W<B0..Bn>" or "S<index>R" and collects read reply bytes.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | ready for a request
// SEND      | registers the current frame byte and its send strobe
// WAIT_DONE | waiting for the transmitter's done (rx open after 'R')
// RECV      | collecting reply bytes B0..B(N-1)
// RESP      | registers the completion pulse
module uart_reg_master #(
  parameter int NUM_BYTES_PER_REG = 4,
  parameter int TIMEOUT_CYCLES    = 1000000
) (
  input  logic                           clock,
  input  logic                           srst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [7:0]                     req_index,
  input  logic [NUM_BYTES_PER_REG*8-1:0] req_wdata,
  output logic                           resp_valid,
  output logic [NUM_BYTES_PER_REG*8-1:0] resp_rdata,
  output logic                           resp_timeout,
  output logic [7:0]                     uart_tx_value,
  output logic                           uart_tx_value_write,
  input  logic                           uart_tx_value_done,
  input  logic [7:0]                     uart_rx_value,
  input  logic                           uart_rx_value_ready
);
  import uart_reg_pkg::*;

  localparam int N     = NUM_BYTES_PER_REG;
  localparam int W     = N * 8;
  localparam int POS_W = $clog2(N + 3);
  localparam int CNT_W = $clog2(N) + 1;

  state_t           state, state_d;
  logic             cap_write;
  logic [7:0]       cap_index;
  logic [W-1:0]     cap_wdata;
  logic [POS_W-1:0] pos;
  logic [CNT_W-1:0] rx_count;
  logic [W-1:0]     rx_data;
  logic             timed_out;

  logic             accept, at_last, rx_window, rx_full, rx_take, rx_last;
  logic             done_evt, tmo_enable, tmo_clear, tmo_expired, tmo_fire;
  logic [7:0]       frame_byte;

  logic             req_ready_d, resp_valid_d, resp_timeout_d, tx_write_d;
  logic [W-1:0]     resp_rdata_d;
  logic [7:0]       tx_value_d;

  assign accept   = req_valid && req_ready;
  assign at_last  = pos == (cap_write ? POS_W'(N + 2) : POS_W'(2));
  assign done_evt = (state == ST_WAIT_DONE) && uart_tx_value_done;
  assign rx_full  = rx_count == CNT_W'(N);
  assign rx_last  = rx_count == CNT_W'(N - 1);

  // The reply may overtake the 'R' done, so rx opens right after the 'R' strobe.
  assign rx_window = (state == ST_RECV) ||
                     ((state == ST_WAIT_DONE) && !cap_write &&
                      (pos == POS_W'(2)) && !uart_tx_value_write);
  assign rx_take   = rx_window && uart_rx_value_ready && !rx_full;

  assign tmo_enable = (state == ST_WAIT_DONE) || (state == ST_RECV);
  assign tmo_clear  = !tmo_enable || (state_d != state) || done_evt || rx_take;
  assign tmo_fire   = tmo_expired && !done_evt && !rx_take;

  uart_reg_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .srst_n (srst_n),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  always_comb begin
    case (pos)
      POS_W'(0): frame_byte = PROTO_SET_REG;
      POS_W'(1): frame_byte = cap_index;
      POS_W'(2): frame_byte = op_byte(cap_write);
      default:   frame_byte = cap_wdata[8*(int'(pos) - 3) +: 8];
    endcase
  end

  always_ff @(posedge clock) begin
    if (!srst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_d = ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (done_evt) begin
          if (!at_last)       state_d = ST_SEND;
          else if (cap_write) state_d = ST_RESP;
          else                state_d = ST_RECV;
        end else if (tmo_fire) begin
          state_d = ST_RESP;
        end
      end
      ST_RECV: begin
        if (rx_full || (rx_take && rx_last)) state_d = ST_RESP;
        else if (tmo_fire)                   state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_d    = (state == ST_IDLE) && !accept;
    resp_valid_d   = state == ST_RESP;
    resp_timeout_d = (state == ST_RESP) && timed_out;
    resp_rdata_d   = (state == ST_RESP) ? rx_data : resp_rdata;
    tx_write_d     = state == ST_SEND;
    tx_value_d     = (state == ST_SEND) ? frame_byte : uart_tx_value;
  end

  always_ff @(posedge clock) begin
    if (!srst_n) begin
      req_ready           <= 1'b1;
      resp_valid          <= 1'b0;
      resp_timeout        <= 1'b0;
      resp_rdata          <= '0;
      uart_tx_value       <= '0;
      uart_tx_value_write <= 1'b0;
    end else begin
      req_ready           <= req_ready_d;
      resp_valid          <= resp_valid_d;
      resp_timeout        <= resp_timeout_d;
      resp_rdata          <= resp_rdata_d;
      uart_tx_value       <= tx_value_d;
      uart_tx_value_write <= tx_write_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!srst_n) begin
      cap_write <= 1'b0;
      cap_index <= '0;
      cap_wdata <= '0;
      pos       <= '0;
      rx_count  <= '0;
      rx_data   <= '0;
      timed_out <= 1'b0;
    end else begin
      if (accept) begin
        cap_write <= req_write;
        cap_index <= req_index;
        cap_wdata <= req_wdata;
        pos       <= '0;
        rx_count  <= '0;
        rx_data   <= '0;
        timed_out <= 1'b0;
      end else if (done_evt && !at_last) begin
        pos <= pos + 1'b1;
      end
      if (rx_take) begin
        rx_data[8*int'(rx_count) +: 8] <= uart_rx_value;
        rx_count                       <= rx_count + 1'b1;
      end
      if (tmo_fire) timed_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_reg_master.sv
// Directed bench for uart_reg_master: a hand-driven transmitter/receiver
// model walks write, read, timeout and mid-frame reset scenarios.
module tb_uart_reg_master;

  logic        clock = 1'b0;
  logic        srst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_index;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_timeout;
  logic [7:0]  uart_tx_value;
  logic        uart_tx_value_write;
  logic        uart_tx_value_done;
  logic [7:0]  uart_rx_value;
  logic        uart_rx_value_ready;

  int errors = 0;
  int checks = 0;

  uart_reg_master #(
    .NUM_BYTES_PER_REG(4),
    .TIMEOUT_CYCLES   (16)
  ) dut (
    .clock              (clock),
    .srst_n             (srst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_write          (req_write),
    .req_index          (req_index),
    .req_wdata          (req_wdata),
    .resp_valid         (resp_valid),
    .resp_rdata         (resp_rdata),
    .resp_timeout       (resp_timeout),
    .uart_tx_value      (uart_tx_value),
    .uart_tx_value_write(uart_tx_value_write),
    .uart_tx_value_done (uart_tx_value_done),
    .uart_rx_value      (uart_rx_value),
    .uart_rx_value_ready(uart_rx_value_ready)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic wr, input logic [7:0] idx, input logic [31:0] wd,
                           input string tag);
    int k;
    k = 0;
    while (!req_ready && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_index = idx;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
    req_wdata = 32'hFFFF_FFFF;
    req_index = 8'hFF;
    check({tag, "_ready_drop"}, req_ready, 1'b0);
  endtask

  // Expects the next strobe one cycle after the caller's last tick, then
  // returns done five cycles after the strobe.
  task automatic send_byte(input logic [7:0] exp, input string tag,
                           input bit rx_with_done, input bit stray);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!uart_tx_value_write && k < 40);
    check({tag, "_strobe"}, uart_tx_value_write, 1'b1);
    check({tag, "_latency"}, k, 1);
    check({tag, "_value"}, uart_tx_value, exp);
    tick();
    check({tag, "_pulse"}, uart_tx_value_write, 1'b0);
    if (stray) begin
      uart_rx_value       = 8'hEE;
      uart_rx_value_ready = 1'b1;
    end
    tick();
    uart_rx_value_ready = 1'b0;
    tick();
    uart_tx_value_done = 1'b1;
    if (rx_with_done) begin
      uart_rx_value       = 8'h11;
      uart_rx_value_ready = 1'b1;
    end
    tick();
    uart_tx_value_done  = 1'b0;
    uart_rx_value_ready = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    uart_rx_value       = b;
    uart_rx_value_ready = 1'b1;
    tick();
    uart_rx_value_ready = 1'b0;
  endtask

  task automatic wait_resp(output int k, output int strobes);
    k = 0;
    strobes = 0;
    do begin
      tick();
      k++;
      if (uart_tx_value_write) strobes++;
    end while (!resp_valid && k < 40);
  endtask

  initial begin
    int k;
    int strobes;

    srst_n              = 1'b0;
    req_valid           = 1'b0;
    req_write           = 1'b0;
    req_index           = 8'h00;
    req_wdata           = 32'h0;
    uart_tx_value_done  = 1'b0;
    uart_rx_value       = 8'h00;
    uart_rx_value_ready = 1'b0;
    repeat (3) tick();
    srst_n = 1'b1;
    tick();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_timeout", resp_timeout, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_tx_value", uart_tx_value, 8'h00);
    check("rst_tx_write", uart_tx_value_write, 1'b0);

    // Write 0xDDCCBBAA to index 0x03
    start_req(1'b1, 8'h03, 32'hDDCC_BBAA, "wr");
    send_byte(8'h53, "wr_s", 1'b0, 1'b0);
    send_byte(8'h03, "wr_idx", 1'b0, 1'b0);
    send_byte(8'h57, "wr_op", 1'b0, 1'b0);
    send_byte(8'hAA, "wr_b0", 1'b0, 1'b0);
    send_byte(8'hBB, "wr_b1", 1'b0, 1'b0);
    send_byte(8'hCC, "wr_b2", 1'b0, 1'b0);
    send_byte(8'hDD, "wr_b3", 1'b0, 1'b0);
    tick();
    check("wr_resp_valid", resp_valid, 1'b1);
    check("wr_resp_timeout", resp_timeout, 1'b0);
    check("wr_resp_rdata", resp_rdata, 32'h0);
    check("wr_ready_low_at_resp", req_ready, 1'b0);
    tick();
    check("wr_ready_back", req_ready, 1'b1);
    check("wr_resp_pulse", resp_valid, 1'b0);

    // Read index 0x05, reply after the 'R' done
    start_req(1'b0, 8'h05, 32'h0, "rd");
    send_byte(8'h53, "rd_s", 1'b0, 1'b0);
    send_byte(8'h05, "rd_idx", 1'b0, 1'b0);
    send_byte(8'h52, "rd_op", 1'b0, 1'b0);
    rx_byte(8'h11);
    tick();
    rx_byte(8'h22);
    tick();
    rx_byte(8'h33);
    tick();
    rx_byte(8'h44);
    check("rd_resp_not_yet", resp_valid, 1'b0);
    tick();
    check("rd_resp_valid", resp_valid, 1'b1);
    check("rd_resp_rdata", resp_rdata, 32'h4433_2211);
    check("rd_resp_timeout", resp_timeout, 1'b0);
    tick();
    check("rd_ready_back", req_ready, 1'b1);

    // Read where B0 coincides with the 'R' done
    start_req(1'b0, 8'h06, 32'h0, "rdx");
    send_byte(8'h53, "rdx_s", 1'b0, 1'b0);
    send_byte(8'h06, "rdx_idx", 1'b0, 1'b0);
    send_byte(8'h52, "rdx_op", 1'b1, 1'b0);
    rx_byte(8'h22);
    tick();
    rx_byte(8'h33);
    tick();
    rx_byte(8'h44);
    tick();
    check("rdx_resp_valid", resp_valid, 1'b1);
    check("rdx_resp_rdata", resp_rdata, 32'h4433_2211);
    tick();

    // Read with only two reply bytes: timeout
    start_req(1'b0, 8'h07, 32'h0, "rdt");
    send_byte(8'h53, "rdt_s", 1'b0, 1'b0);
    send_byte(8'h07, "rdt_idx", 1'b0, 1'b0);
    send_byte(8'h52, "rdt_op", 1'b0, 1'b0);
    rx_byte(8'h11);
    tick();
    rx_byte(8'h22);
    check("rdt_rdata_held", resp_rdata, 32'h4433_2211);
    wait_resp(k, strobes);
    check("rdt_resp_valid", resp_valid, 1'b1);
    check("rdt_latency", k, 17);
    check("rdt_resp_timeout", resp_timeout, 1'b1);
    check("rdt_resp_rdata", resp_rdata, 32'h0000_2211);
    tick();
    check("rdt_ready_back", req_ready, 1'b1);
    check("rdt_timeout_pulse", resp_timeout, 1'b0);

    // Write where the transmitter never returns done after 'S'
    start_req(1'b1, 8'h09, 32'h1234_5678, "wrt");
    k = 0;
    do begin
      tick();
      k++;
    end while (!uart_tx_value_write && k < 40);
    check("wrt_s_strobe", uart_tx_value_write, 1'b1);
    check("wrt_s_value", uart_tx_value, 8'h53);
    wait_resp(k, strobes);
    check("wrt_resp_valid", resp_valid, 1'b1);
    check("wrt_latency", k, 17);
    check("wrt_extra_strobes", strobes, 0);
    check("wrt_resp_timeout", resp_timeout, 1'b1);
    check("wrt_resp_rdata", resp_rdata, 32'h0);
    tick();

    // Reset during the B1 byte of a write
    start_req(1'b1, 8'h0A, 32'h4433_2211, "rst");
    send_byte(8'h53, "rst_s", 1'b0, 1'b0);
    send_byte(8'h0A, "rst_idx", 1'b0, 1'b0);
    send_byte(8'h57, "rst_op", 1'b0, 1'b0);
    send_byte(8'h11, "rst_b0", 1'b0, 1'b0);
    k = 0;
    do begin
      tick();
      k++;
    end while (!uart_tx_value_write && k < 40);
    check("rst_b1_value", uart_tx_value, 8'h22);
    tick();
    srst_n = 1'b0;
    tick();
    check("mid_rst_req_ready", req_ready, 1'b1);
    check("mid_rst_resp_valid", resp_valid, 1'b0);
    check("mid_rst_resp_timeout", resp_timeout, 1'b0);
    check("mid_rst_resp_rdata", resp_rdata, 32'h0);
    check("mid_rst_tx_value", uart_tx_value, 8'h00);
    check("mid_rst_tx_write", uart_tx_value_write, 1'b0);
    srst_n             = 1'b1;
    uart_tx_value_done = 1'b1;
    tick();
    uart_tx_value_done = 1'b0;
    rx_byte(8'hEE);
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (uart_tx_value_write) strobes++;
    end
    check("post_rst_no_strobes", strobes, 0);
    check("post_rst_idle_valid", resp_valid, 1'b0);

    // Read after reset, with a stray byte during the 'S' wait
    start_req(1'b0, 8'h0B, 32'h0, "prd");
    send_byte(8'h53, "prd_s", 1'b0, 1'b1);
    send_byte(8'h0B, "prd_idx", 1'b0, 1'b0);
    send_byte(8'h52, "prd_op", 1'b0, 1'b0);
    rx_byte(8'hA1);
    tick();
    rx_byte(8'hB2);
    tick();
    rx_byte(8'hC3);
    tick();
    rx_byte(8'hD4);
    tick();
    check("prd_resp_valid", resp_valid, 1'b1);
    check("prd_resp_rdata", resp_rdata, 32'hD4C3_B2A1);
    check("prd_resp_timeout", resp_timeout, 1'b0);
    tick();
    check("prd_ready_back", req_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_reg_master.md
# uart_reg_master

Initiator side of the UART register protocol: accepts a single register read or write request from local logic and serializes it onto a byte-wide UART transmit interface as "S<index>W<B0..B3>" or "S<index>R". For reads, it collects the returned B0..B3 bytes from the UART receive interface and presents them as one word. It sits between a host-side controller (sequencer or test logic) and a UART transceiver, and talks to the register-interface responder on the far end of the serial link.

## Interface
- NUM_BYTES_PER_REG, 4: bytes per register; power of two, at least 1.
- TIMEOUT_CYCLES, 1000000: idle cycles allowed while waiting for tx done or the next rx byte; must be at least 2.
- clock  in  1  single clock; every register is updated on its rising edge.
- srst_n  in  1  reset, synchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_index  in  8  register index, sent verbatim.
- req_wdata  in  NUM_BYTES_PER_REG*8  write data; byte k is bits [8k+7:8k].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  NUM_BYTES_PER_REG*8  read data, byte k from received B(k).
- resp_timeout  out  1  qualifies resp_valid; 1 = transaction aborted.
- uart_tx_value  out  8  byte to transmit.
- uart_tx_value_write  out  1  one-cycle send strobe.
- uart_tx_value_done  in  1  one-cycle pulse when the transmitter has finished the byte.
- uart_rx_value  in  8  received byte.
- uart_rx_value_ready  in  1  one-cycle pulse that qualifies uart_rx_value.

## Operation
- All outputs are registered.
- Reset values:
  - req_ready=1 from the first cycle after reset is released.
  - resp_valid=0, resp_timeout=0, resp_rdata=0.
  - uart_tx_value=0, uart_tx_value_write=0.
- Request capture: the request is captured when req_valid && req_ready; req_ready then drops the next cycle.
- The captured request (write, index, wdata) is held internally; request inputs are ignored until the block is back in IDLE.
- Frame bytes, in order, selected by a frame counter:
  - position 0: 'S' (0x53);
  - position 1: req_index;
  - position 2: 'W' (0x57) or 'R' (0x52);
  - positions 3..3+N-1 (writes only): B0..B(N-1), with B0 the LSB.
- State machine:
  - IDLE: on accept, go to SEND.
  - SEND: drive uart_tx_value and pulse uart_tx_value_write for exactly one cycle; go to WAIT_DONE.
  - WAIT_DONE, on done with more bytes to send: increment the frame counter and go to SEND.
  - WAIT_DONE, on done with the last write byte sent: go to RESP.
  - WAIT_DONE, on done with 'R' sent: go to RECV.
  - RECV: each uart_rx_value_ready stores the byte into slot rx_count and increments rx_count; after the Nth byte, go to RESP.
  - RESP: pulse resp_valid; go to IDLE.
- Receive window: rx capture is enabled from the cycle after the 'R' strobe, including WAIT_DONE. A reply byte that arrives before, or in the same cycle as, the 'R' done is kept.
- Bytes arriving in any other state are dropped; uart_tx_value_done outside WAIT_DONE is ignored.
- Timeout: a counter runs in WAIT_DONE and RECV.
  - It clears on state entry, on each done, and on each rx byte.
  - Reaching TIMEOUT_CYCLES goes to RESP with resp_timeout=1.
  - On timeout, resp_rdata holds the bytes received so far; unreceived bytes are 0.
- rx slots clear to 0 on request accept.
- resp_rdata is 0 after a write and stays stable until the next resp_valid.
- Reset mid-frame: the frame is abandoned and nothing more is sent. The far-end responder resynchronizes on the next 'S' it sees in its idle state; no recovery bytes are emitted.

## Timing
- Accept in cycle t gives uart_tx_value_write=1 with 'S' in cycle t+2 (SEND registered output).
- Done seen in cycle d gives the next byte strobe at d+2.
- Inter-byte gap is therefore 2 cycles plus the transmitter's own duration.
- Write: resp_valid at d_last+2, where d_last is the cycle of the final done.
- Read: resp_valid two cycles after the Nth uart_rx_value_ready.
- req_ready returns to 1 the cycle after resp_valid.
- Minimum back-to-back requests: accept, then one cycle after resp_valid.

## Structure
- Shared package uart_reg_pkg holds:
  - PROTO_SET_REG="S", PROTO_READ="R", PROTO_WRITE="W";
  - the state enumeration.
- The same constants are reused by the responder.
- Sub-module uart_reg_timeout: a loadable down-counter with clear and an expired flag, parameterized by TIMEOUT_CYCLES.
- Expected implementation size is about 200 RTL lines.

## Test plan
- Write, index 0x03, wdata 0xDDCCBBAA, with done 5 cycles after each strobe: tx sequence 53,03,57,AA,BB,CC,DD; then resp_valid=1, resp_timeout=0, resp_rdata=0.
- Read, index 0x05, rx bytes 11,22,33,44 after 'R' done: tx sequence 53,05,52; resp_rdata=0x44332211; resp_valid two cycles after the byte 0x44.
- Read where rx byte 0x11 arrives in the same cycle as the 'R' done: the byte is captured and resp_rdata still equals 0x44332211.
- Read with TIMEOUT_CYCLES=16 and only 0x11,0x22 returned: resp_timeout=1, resp_rdata=0x00002211, req_ready=1 on the next cycle.
- Write where the transmitter never returns done after 'S': timeout after 16 cycles, no further strobes, resp_timeout=1.
- Reset (srst_n=0) during the B1 byte: all outputs at reset values the next cycle; a following read completes normally, with stray rx bytes before it ignored.
